// File: rtl/ieee_adder_normalize_round.sv
// Normalize-and-round stage after the floating-point adder's significand add.
// Takes the raw sum: sign, larger exponent and an unnormalized significand
// {carry, hidden, fraction, guard bits}. It renormalizes one step per cycle,
// rounds to nearest-even and packs an IEEE754 word. Only one operation is in
// flight, with a valid/ready handshake on both sides.
module ieee_adder_normalize_round #(
  parameter int EXPO_LEN   = 8,
  parameter int SIGNIF_LEN = 23,
  parameter int GUARD_LEN  = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_sign,
  input  logic [EXPO_LEN-1:0]                in_exponent,
  input  logic [SIGNIF_LEN+GUARD_LEN+1:0]    in_significand,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [EXPO_LEN+SIGNIF_LEN:0]       out_number
);

  localparam int SIG_W     = SIGNIF_LEN + GUARD_LEN + 2;
  localparam int CARRY_B   = SIG_W - 1;
  localparam int HIDDEN_B  = SIG_W - 2;
  localparam int MANT_W    = SIGNIF_LEN + 1;
  localparam int OUT_W     = 1 + EXPO_LEN + SIGNIF_LEN;
  localparam int SHIFT_MAX = SIGNIF_LEN + GUARD_LEN;
  localparam int CNT_W     = $clog2(SHIFT_MAX + 1);

  // Exponent is carried one bit wider so that overflow into all-ones is visible.
  localparam logic [EXPO_LEN:0]  EXP_ONES  = {1'b0, {EXPO_LEN{1'b1}}};
  localparam logic [EXPO_LEN:0]  EXP_ZERO  = '0;
  localparam logic [EXPO_LEN:0]  EXP_ONE   = (EXPO_LEN+1)'(1);
  localparam logic [CNT_W-1:0]   CNT_LIMIT = CNT_W'(SHIFT_MAX);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t                state_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [OUT_W-1:0]      out_number_q;
  logic                  sign_q;
  logic [EXPO_LEN:0]     exp_q;
  logic [SIG_W-1:0]      sig_q;
  logic [CNT_W-1:0]      cnt_q;

  // Datapath next values produced from the current registers.
  logic [SIG_W-1:0]      sig_rshift_d;
  logic [SIG_W-1:0]      sig_lshift_d;
  logic [EXPO_LEN:0]     exp_inc_d;
  logic [EXPO_LEN:0]     exp_dec_d;
  logic [MANT_W:0]       mant_rnd_d;
  logic [EXPO_LEN:0]     exp_rnd_d;
  logic [SIGNIF_LEN-1:0] frac_rnd_d;
  logic [OUT_W-1:0]      round_word_d;

  // Round-to-nearest-even decision: guard set and (sticky or fraction LSB odd).
  function automatic logic rne_inc(input logic [SIG_W-1:0] sig);
    logic g, s, l;
    g = sig[GUARD_LEN-1];
    s = |sig[GUARD_LEN-2:0];
    l = sig[GUARD_LEN];
    return g & (s | l);
  endfunction

  // Saturated result: signed infinity.
  function automatic logic [OUT_W-1:0] inf_word(input logic sign);
    return {sign, {EXPO_LEN{1'b1}}, {SIGNIF_LEN{1'b0}}};
  endfunction

  // Normalization step candidates and the rounded, packed word.
  always_comb begin
    // Right shift keeps the dropped bit alive as sticky in the LSB.
    sig_rshift_d = {1'b0, sig_q[SIG_W-1:2], sig_q[1] | sig_q[0]};
    sig_lshift_d = {sig_q[SIG_W-2:0], 1'b0};
    exp_inc_d    = exp_q + EXP_ONE;
    exp_dec_d    = exp_q - EXP_ONE;

    mant_rnd_d   = {1'b0, sig_q[HIDDEN_B:GUARD_LEN]} + {{MANT_W{1'b0}}, rne_inc(sig_q)};
    if (mant_rnd_d[MANT_W]) begin
      // Rounding carried past the hidden bit: 1.0 at the next binade.
      exp_rnd_d  = exp_inc_d;
      frac_rnd_d = '0;
    end else begin
      // A subnormal that rounds up into the hidden bit becomes the smallest normal.
      exp_rnd_d  = (exp_q == EXP_ZERO && mant_rnd_d[MANT_W-1]) ? EXP_ONE : exp_q;
      frac_rnd_d = mant_rnd_d[SIGNIF_LEN-1:0];
    end

    if (exp_rnd_d == EXP_ONES) begin
      round_word_d = inf_word(sign_q);
    end else begin
      round_word_d = {sign_q, exp_rnd_d[EXPO_LEN-1:0], frac_rnd_d};
    end
  end

  // Control FSM with registered handshake outputs and the operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_number_q <= '0;
      sign_q       <= 1'b0;
      exp_q        <= '0;
      sig_q        <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q     <= in_sign;
            exp_q      <= {1'b0, in_exponent};
            sig_q      <= in_significand;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            if (&in_exponent) begin
              // Inf/NaN: keep the fraction payload untouched.
              out_number_q <= {in_sign, in_exponent,
                               in_significand[SIGNIF_LEN+GUARD_LEN-1:GUARD_LEN]};
              out_valid_q  <= 1'b1;
              state_q      <= DONE;
            end else if (in_significand == '0) begin
              out_number_q <= {in_sign, {(EXPO_LEN+SIGNIF_LEN){1'b0}}};
              out_valid_q  <= 1'b1;
              state_q      <= DONE;
            end else begin
              state_q      <= NORM;
            end
          end
        end

        NORM: begin
          if (sig_q[CARRY_B]) begin
            sig_q <= sig_rshift_d;
            exp_q <= exp_inc_d;
            if (exp_inc_d == EXP_ONES) begin
              out_number_q <= inf_word(sign_q);
              out_valid_q  <= 1'b1;
              state_q      <= DONE;
            end
          end else if (!sig_q[HIDDEN_B]) begin
            if (exp_q > EXP_ONE && cnt_q < CNT_LIMIT) begin
              sig_q <= sig_lshift_d;
              exp_q <= exp_dec_d;
              cnt_q <= cnt_q + CNT_ONE;
            end else if (exp_q == EXP_ONE) begin
              // Cannot go lower: the value is subnormal, no shift this step.
              exp_q   <= EXP_ZERO;
              state_q <= ROUND;
            end else begin
              state_q <= ROUND;
            end
          end else begin
            state_q <= ROUND;
          end
        end

        ROUND: begin
          out_number_q <= round_word_d;
          out_valid_q  <= 1'b1;
          state_q      <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_number = out_number_q;

endmodule

// File: tb/tb_ieee_adder_normalize_round.sv
// Directed bench for ieee_adder_normalize_round (single precision layout).
module tb_ieee_adder_normalize_round;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exponent = '0;
  logic [27:0] in_significand = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_number;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ieee_adder_normalize_round #(
    .EXPO_LEN  (8),
    .SIGNIF_LEN(23),
    .GUARD_LEN (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exponent   (in_exponent),
    .in_significand(in_significand),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_number    (out_number)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One transaction with out_ready high. exp_lat >= 0: exact number of edges
  // after the accept edge until out_valid; exp_lat < 0: bypass, at most one.
  task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                        input logic [27:0] m, input logic [31:0] expw, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid       = 1'b1;
    in_sign        = s;
    in_exponent    = e;
    in_significand = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_word"}, out_number, expw);
    if (exp_lat >= 0) check({tag, "_lat"}, lat, exp_lat);
    else              check({tag, "_lat_le1"}, {31'd0, (lat <= 1)}, 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int  lat;
    logic seen;

    // Reset state
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_number", out_number, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal values and carry renormalization
    run_op("one",       1'b0, 8'd127, 28'h4000000, 32'h3F800000, 2);
    run_op("carry",     1'b0, 8'd127, 28'h8000000, 32'h40000000, 3);
    // Cancellation: 23 left shifts, exponent 127-23=104
    run_op("cancel",    1'b0, 8'd127, 28'h0000008, 32'h34000000, 25);
    // exp 3: two left shifts reach exp 1, then exp:=0 with fraction 0x4
    run_op("subn_e3",   1'b0, 8'd3,   28'h0000008, 32'h00000004, 4);
    run_op("subn_e1",   1'b0, 8'd1,   28'h0000008, 32'h00000001, 2);
    // Round to nearest even
    run_op("tie_even",  1'b0, 8'd127, 28'h4000004, 32'h3F800000, 2);
    run_op("tie_odd",   1'b0, 8'd127, 28'h400000C, 32'h3F800002, 2);
    run_op("above",     1'b0, 8'd127, 28'h4000005, 32'h3F800001, 2);
    // Sticky from the right shift turns a tie into round-up
    run_op("sticky",    1'b0, 8'd127, 28'h8000009, 32'h40000001, 3);
    // Subnormal rounds into the hidden bit -> smallest normal
    run_op("promote",   1'b0, 8'd1,   28'h3FFFFFC, 32'h00800000, 2);
    // Overflow to infinity
    run_op("ovf_carry", 1'b0, 8'd254, 28'h8000000, 32'h7F800000, 1);
    run_op("ovf_round", 1'b0, 8'd254, 28'h7FFFFFC, 32'h7F800000, 2);
    run_op("ovf_neg",   1'b1, 8'd254, 28'h8000000, 32'hFF800000, 1);
    // Bypass paths
    run_op("neg_zero",  1'b1, 8'd100, 28'h0000000, 32'h80000000, -1);
    run_op("nan",       1'b0, 8'd255, 28'h6000000, 32'h7FC00000, -1);

    // Back-pressure: result held, new input ignored
    @(negedge clk);
    out_ready      = 1'b0;
    in_valid       = 1'b1;
    in_sign        = 1'b0;
    in_exponent    = 8'd127;
    in_significand = 28'h4000000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid       = 1'b1;
      in_exponent    = 8'd128;
      in_significand = 28'h4000000;
      @(posedge clk);
      #1;
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_word",  out_number, 32'h3F800000);
      check("bp_in_ready",   {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, in_ready},  32'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("bp_ignored_input", {31'd0, seen}, 32'd0);

    // Asynchronous reset in the middle of a long normalization
    @(negedge clk);
    in_valid       = 1'b1;
    in_exponent    = 8'd127;
    in_significand = 28'h0000008;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid",  {31'd0, out_valid}, 32'd0);
    check("arst_in_ready",   {31'd0, in_ready},  32'd1);
    check("arst_out_number", out_number, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("arst_no_stale", {31'd0, seen}, 32'd0);
    run_op("post_rst", 1'b1, 8'd127, 28'h4000000, 32'hBF800000, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
